// File: rtl/opll_audio_dac_out_if.sv
// Sample/control bus between the OPLL accumulator and the 1-bit audio output stage.
// The master drives clock enable, strobe, packed samples and the requested mode;
// the slave (the DAC stage) returns the per-channel pins and the period pulse.
interface opll_audio_dac_out_if #(
    parameter int N_CH = 2,
    parameter int IN_W = 16
);
    logic                   i_cen;
    logic                   i_strb;
    logic [N_CH*IN_W-1:0]   i_sample;
    logic                   i_mode;
    logic [N_CH-1:0]        o_dac;
    logic                   o_period;

    modport master (
        output i_cen, i_strb, i_sample, i_mode,
        input  o_dac, o_period
    );

    modport slave (
        input  i_cen, i_strb, i_sample, i_mode,
        output o_dac, o_period
    );
endinterface

// File: rtl/opll_audio_dac_out.sv
// Multi-channel 1-bit audio output stage.
// Latches signed PCM samples on the strobe, converts them to offset binary and
// drives one pin per channel as either PWM or first-order delta-sigma.
// The mode is chosen at run time but only takes effect at a PWM period boundary.
// Optional build macro OPLL_DAC_DITHER_EN: adds a 16-bit Galois LFSR that dithers
// the truncation of each sample to the PWM duty width.
module opll_audio_dac_out #(
    parameter int N_CH     = 2,
    parameter int IN_W     = 16,
    parameter int PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    opll_audio_dac_out_if.slave   bus
);

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_DS  = 1'b1
    } mode_e;

    localparam logic [IN_W-1:0]     HOLD_MID = IN_W'(2 ** (IN_W - 1));
    localparam logic [PWM_BITS-1:0] DUTY_MID = PWM_BITS'(2 ** (PWM_BITS - 1));
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

    logic [IN_W-1:0]     hold     [N_CH];
    logic [PWM_BITS-1:0] duty     [N_CH];
    logic [PWM_BITS-1:0] duty_next[N_CH];
    logic [IN_W-1:0]     acc      [N_CH];
    logic [IN_W:0]       ds_sum   [N_CH];
    logic [PWM_BITS-1:0] cnt;
    mode_e               mode;
    logic [N_CH-1:0]     dac_q;
    logic                period_q;
    logic                boundary;

    // Last enabled cycle of a PWM period: duty, mode and dither all advance here.
    assign boundary = bus.i_cen && (cnt == CNT_MAX);

    assign bus.o_dac    = dac_q;
    assign bus.o_period = period_q;

`ifdef OPLL_DAC_DITHER_EN
    // Bits of the sample discarded by the duty truncation; zero when nothing is dropped.
    localparam logic [IN_W-1:0] FRAC_MASK =
        (IN_W > PWM_BITS) ? IN_W'((64'd1 << (IN_W - PWM_BITS)) - 64'd1) : '0;

    logic [15:0] lfsr;

    // Dither source: x^16+x^14+x^13+x^11+1 Galois LFSR, one step per PWM period.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (boundary) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`endif

    // Duty value each channel would load at the next boundary.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            duty_next[k] = hold[k][IN_W-1 -: PWM_BITS];
`ifdef OPLL_DAC_DITHER_EN
            if (((hold[k] & FRAC_MASK) > (IN_W'(lfsr) & FRAC_MASK)) &&
                (duty_next[k] != CNT_MAX)) begin
                duty_next[k] = duty_next[k] + 1'b1;
            end
`endif
        end
    end

    // Delta-sigma adder per channel; the carry out is the output bit.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ds_sum[k] = {1'b0, acc[k]} + {1'b0, hold[k]};
        end
    end

    // Sample capture: runs on every strobe regardless of clock enable, last strobe wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the hold array is a handful of flops, not a RAM, so it is reset like any other register.
            for (int k = 0; k < N_CH; k++) begin
                hold[k] <= HOLD_MID;
            end
        end else if (bus.i_strb) begin
            // Inverting the sign bit turns two's complement into offset binary.
            for (int k = 0; k < N_CH; k++) begin
                hold[k] <= bus.i_sample[k*IN_W +: IN_W] ^ HOLD_MID;
            end
        end
    end

    // PWM counter, period pulse, duty/mode reload and per-channel modulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
            cnt      <= '0;
            mode     <= MODE_PWM;
            period_q <= 1'b0;
            dac_q    <= '0;
            for (int k = 0; k < N_CH; k++) begin
                duty[k] <= DUTY_MID;
                acc[k]  <= '0;
            end
        end else begin
            period_q <= boundary;
            if (bus.i_cen) begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < N_CH; k++) begin
                    if (mode == MODE_PWM) begin
                        dac_q[k] <= (cnt < duty[k]);
                    end else begin
                        acc[k]   <= ds_sum[k][IN_W-1:0];
                        dac_q[k] <= ds_sum[k][IN_W];
                    end
                end
                if (boundary) begin
                    // A strobe in this same cycle is not yet in hold, so it lands one period later.
                    for (int k = 0; k < N_CH; k++) begin
                        duty[k] <= duty_next[k];
                    end
                    mode <= mode_e'(bus.i_mode);
                    // Entering delta-sigma starts every accumulator from zero.
                    if (bus.i_mode && (mode == MODE_PWM)) begin
                        for (int k = 0; k < N_CH; k++) begin
                            acc[k] <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_opll_audio_dac_out.sv
// Self-checking bench for opll_audio_dac_out: a behavioural model predicts every
// output cycle, and directed scenarios pin the model with hand-computed counts.
`timescale 1ns/1ps
module tb_opll_audio_dac_out;
    localparam int N_CH     = 2;
    localparam int IN_W     = 16;
    localparam int PWM_BITS = 8;
    localparam int PERIOD   = 2 ** PWM_BITS;
    localparam int FULL     = 2 ** IN_W;
    localparam int HALF     = 2 ** (IN_W - 1);
    localparam int FRAC     = 2 ** (IN_W - PWM_BITS);

    logic clk = 1'b0;
    logic rst;

    opll_audio_dac_out_if #(.N_CH(N_CH), .IN_W(IN_W)) bus ();

    opll_audio_dac_out #(.N_CH(N_CH), .IN_W(IN_W), .PWM_BITS(PWM_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_phase;                 // enabled cycles since reset, modulo the period
    int m_hold [N_CH];           // latest sample as an unsigned offset value
    int m_duty [N_CH];           // high cycles per period in force now
    int m_acc  [N_CH];
    int m_mode;                  // 0 PWM, 1 delta-sigma
    int m_lfsr;
    logic [N_CH-1:0] exp_dac    = '0;
    logic            exp_period = 1'b0;
    bit              chk_en     = 1'b0;

    function automatic int to_duty(input int h, input int lfsr);
        int base;
        base = h / FRAC;
`ifdef OPLL_DAC_DITHER_EN
        if ((h % FRAC) > (lfsr % FRAC) && base < PERIOD - 1) base++;
`endif
        return base;
    endfunction

    // Predicts the outputs visible after the next clock edge for the given inputs.
    task automatic model_step(input logic r, input logic cen, input logic strb,
                              input logic [N_CH*IN_W-1:0] smp, input logic md);
        bit bnd;
        if (r) begin
            m_phase = 0;
            m_mode  = 0;
            m_lfsr  = 'hACE1;
            for (int k = 0; k < N_CH; k++) begin
                m_hold[k] = HALF;
                m_duty[k] = PERIOD / 2;
                m_acc[k]  = 0;
            end
            exp_dac    = '0;
            exp_period = 1'b0;
            return;
        end
        bnd = cen && (m_phase == PERIOD - 1);
        exp_period = bnd;
        if (cen) begin
            for (int k = 0; k < N_CH; k++) begin
                if (m_mode == 0) begin
                    exp_dac[k] = (m_phase < m_duty[k]);
                end else begin
                    int sum;
                    sum = m_acc[k] + m_hold[k];
                    exp_dac[k] = (sum >= FULL);
                    m_acc[k] = sum % FULL;
                end
            end
        end
        if (bnd) begin
            for (int k = 0; k < N_CH; k++) m_duty[k] = to_duty(m_hold[k], m_lfsr);
            if (md && m_mode == 0) for (int k = 0; k < N_CH; k++) m_acc[k] = 0;
            m_mode = md ? 1 : 0;
            if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 'hB400;
            else                 m_lfsr = m_lfsr / 2;
        end
        if (cen) m_phase = (m_phase + 1) % PERIOD;
        if (strb) begin
            for (int k = 0; k < N_CH; k++) begin
                int s;
                s = $signed(smp[k*IN_W +: IN_W]);
                m_hold[k] = s + HALF;
            end
        end
    endtask

    // ---------------- compare process and window statistics ----------------
    int n_pulses = 0;
    int len_acc  = 0;
    int last_len = 0;
    int hi_acc  [N_CH] = '{default: 0};
    int last_hi [N_CH] = '{default: 0};

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("o_dac", bus.o_dac, exp_dac);
            check("o_period", bus.o_period, exp_period);
        end
        len_acc++;
        for (int k = 0; k < N_CH; k++) hi_acc[k] += int'(bus.o_dac[k]);
        if (bus.o_period === 1'b1) begin
            last_len = len_acc;
            len_acc  = 0;
            for (int k = 0; k < N_CH; k++) begin
                last_hi[k] = hi_acc[k];
                hi_acc[k]  = 0;
            end
            n_pulses++;
        end
    end

    // ---------------- driver ----------------
    logic                 d_rst  = 1'b1;
    logic                 d_strb = 1'b0;
    logic                 d_mode = 1'b0;
    logic [N_CH*IN_W-1:0] d_smp  = '0;
    int                   cen_pat = 0;   // 0 always, 1 one-in-four, 2 random
    int                   cyc     = 0;

    task automatic tick();
        logic cen;
        case (cen_pat)
            1:       cen = (cyc % 4 == 0);
            2:       cen = ($urandom_range(0, 3) != 0);
            default: cen = 1'b1;
        endcase
        cyc++;
        rst          = d_rst;
        bus.i_cen    = cen;
        bus.i_strb   = d_strb;
        bus.i_sample = d_smp;
        bus.i_mode   = d_mode;
        model_step(d_rst, cen, d_strb, d_smp, d_mode);
        chk_en = 1'b1;
        @(posedge clk);
        #3;
    endtask

    task automatic strobe(input logic [15:0] s0, input logic [15:0] s1);
        d_smp  = {s1, s0};
        d_strb = 1'b1;
        tick();
        d_strb = 1'b0;
    endtask

    task automatic run_to_pulse();
        int start;
        int guard;
        start = n_pulses;
        guard = 0;
        while (n_pulses == start && guard < 3000) begin
            tick();
            guard++;
        end
        check("pulse_wait", (n_pulses != start), 1);
    endtask

    initial begin
        int hi;
        int sum;

        // Reset, then midscale PWM on both channels.
        d_rst = 1'b1;
        tick();
        check("reset_dac", bus.o_dac, 2'b00);
        tick();
        d_rst = 1'b0;
        repeat (3) run_to_pulse();
        check("mid_len", last_len, 256);
        check("mid_hi0", last_hi[0], 128);
        check("mid_hi1", last_hi[1], 128);

        // Full-scale extremes.
        strobe(16'h7FFF, 16'h8000);
        repeat (2) run_to_pulse();
        check("max_hi0", last_hi[0], 255);
        check("min_hi1", last_hi[1], 0);

        // Two strobes in one period: the last one wins.
        run_to_pulse();
        strobe(16'h4000, 16'h0000);
        repeat (20) tick();
        strobe(16'h1234, 16'h0000);
        run_to_pulse();
        run_to_pulse();
        check("last_wins_hi0", last_hi[0], 8'h92);

        // Strobe on the boundary cycle applies one period later.
        repeat (255) tick();
        strobe(16'h2000, 16'h0000);
        check("bnd_pulse", bus.o_period, 1'b1);
        run_to_pulse();
        check("bnd_old_hi0", last_hi[0], 8'h92);
        run_to_pulse();
        check("bnd_new_hi0", last_hi[0], 8'hA0);

        // Mode request mid-period takes effect at the boundary.
        strobe(16'h4000, 16'h8000);
        repeat (10) tick();
        d_mode = 1'b1;
        run_to_pulse();
        hi = 0;
        sum = 0;
        repeat (1024) begin
            tick();
            hi  += int'(bus.o_dac[0]);
            sum += int'(bus.o_dac[1]);
        end
        check_range("ds_density0", hi, 764, 772);
        check("ds_density1", sum, 0);

        // Back to PWM with quarter-rate clock enable.
        d_mode = 1'b0;
        strobe(16'h0000, 16'h0000);
        run_to_pulse();
        cen_pat = 1;
        repeat (2) run_to_pulse();
        check("cen_len", last_len, 1024);
        check("cen_hi0", last_hi[0], 512);
        check("cen_hi1", last_hi[1], 512);

        // Reset in the middle of a period.
        repeat (137) tick();
        d_rst = 1'b1;
        tick();
        check("midrst_dac", bus.o_dac, 2'b00);
        check("midrst_period", bus.o_period, 1'b0);
        d_rst = 1'b0;
        cen_pat = 0;

        // Sample with half an LSB of duty below the truncation point.
        strobe(16'h0080, 16'h0080);
        repeat (2) run_to_pulse();
        sum = 0;
        repeat (64) begin
            run_to_pulse();
            sum += last_hi[0];
`ifndef OPLL_DAC_DITHER_EN
            check("trunc_hi0", last_hi[0], 128);
`endif
        end
`ifdef OPLL_DAC_DITHER_EN
        check_range("dither_sum", sum, 8208, 8240);
`endif

        // Randomised traffic against the model.
        cen_pat = 2;
        for (int i = 0; i < 6000; i++) begin
            d_strb = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       d_smp = {16'h7FFF, 16'h8000};
                1:       d_smp = {16'h8000, 16'h7FFF};
                default: d_smp = {16'($urandom), 16'($urandom)};
            endcase
            if ($urandom_range(0, 299) == 0) d_mode = ~d_mode;
            d_rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        d_rst  = 1'b0;
        d_strb = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
